regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- REGADDRSIZE, 5, register address width (mipspkg).
- REGSIZE, 32, register data width (mipspkg).
- NREQ, 3, requester count, fixed at 3 (0 = ALU, 1 = load, 2 = mul/div).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on posedge.
- reset, in, 1, asynchronous, active-high reset.
- req_valid, in, NREQ, write-back request per requester.
- req_addr, in, NREQ*REGADDRSIZE, destination register per requester; slice i belongs to requester i.
- req_data, in, NREQ*REGSIZE, write data per requester; slice i belongs to requester i.
- req_ready, out, NREQ, grant; transfer = valid & ready.
- wb_hold, in, 1, pipeline stall; blocks all grants.
- w_enable, out, 1, regfile write enable.
- w_addr1, out, REGADDRSIZE, regfile write address.
- w_data1, out, REGSIZE, regfile write data.
- grant_id, out, 2, index of the requester in the current write slot.
- r_addr1, in, REGADDRSIZE, regfile read address, port 1.
- r_addr2, in, REGADDRSIZE, regfile read address, port 2.
- rf_rdata1, in, REGSIZE, regfile read data, port 1.
- rf_rdata2, in, REGSIZE, regfile read data, port 2.
- fwd_data1, out, REGSIZE, read data seen by the datapath, port 1.
- fwd_data2, out, REGSIZE, read data seen by the datapath, port 2.

REQ-003 The block SHALL use one clock (clk) and an asynchronous, active-high reset (reset).

Function
REQ-004 The block SHALL assert at most one req_ready bit per cycle; req_ready SHALL be combinational from req_valid, wb_hold and the round-robin pointer.
REQ-005 Arbitration SHALL be round-robin: the search starts at (last_grant+1) mod 3, and the first valid requester wins.
REQ-006 last_grant SHALL update only on a completed transfer.
REQ-007 When wb_hold=1, req_ready SHALL be 0 and last_grant SHALL NOT change.
REQ-008 A transfer SHALL be registered into w_enable, w_addr1, w_data1 and grant_id on the next posedge (1-cycle latency); the regfile commits it on the following negedge.
REQ-009 w_enable SHALL be 1 only in the cycle after a transfer; otherwise it SHALL be 0, and w_addr1/w_data1 SHALL hold their last values.
REQ-010 A transfer with req_addr=0 SHALL complete normally (ready asserted, pointer advanced), but w_enable SHALL be 0 for that slot.
REQ-011 A requester SHALL hold addr and data stable while valid and not ready; the block SHALL NOT sample unselected requesters.
REQ-012 Two requesters targeting the same register SHALL be serialized in grant order; the later grant's data SHALL remain in the regfile.
REQ-013 Throughput SHALL be one transfer per cycle when wb_hold=0 and any request is valid.
REQ-014 With all three requesters continuously valid, the grant order SHALL be 0,1,2,0,...; each requester SHALL wait at most 2 cycles.
REQ-015 grant_id SHALL be 2'b11 in cycles with w_enable=0.

Reset
REQ-016 While reset=1, the following SHALL hold immediately and asynchronously: w_enable=0, w_addr1=0, w_data1=0, grant_id=2'b11, last_grant=2, req_ready=0.
REQ-017 After reset deasserts, requester 0 SHALL hold the first priority.
REQ-018 A transfer in flight at reset SHALL be dropped; no write is issued for it.

Configuration
REQ-019 With macro WB_FORWARD_EN defined, fwd_dataN SHALL equal w_data1 when w_enable=1, w_addr1==r_addrN and r_addrN!=0; otherwise it SHALL equal rf_rdataN (combinational, N=1,2).
REQ-020 Without WB_FORWARD_EN, fwd_dataN SHALL equal rf_rdataN unconditionally.
REQ-021 The ports SHALL be identical in both builds.

Verification
REQ-022 Single request: req_valid=3'b010, addr1=5, data1=0xDEAD_BEEF -> req_ready=3'b010; next cycle w_enable=1, w_addr1=5, w_data1=0xDEADBEEF, grant_id=1.
REQ-023 Round-robin: req_valid=3'b111 for 6 cycles after reset -> grant_id sequence 0,1,2,0,1,2.
REQ-024 Register-0 write: requester 0, addr 0, data 0x1234 -> ready=1; next cycle w_enable=0; regfile r0 still reads 0.
REQ-025 Hold: wb_hold=1 for 3 cycles with req_valid=3'b101 -> req_ready=0 and w_enable=0; after release, grant goes to requester 0, then 2.
REQ-026 Reset mid-op: reset asserted in the cycle after a transfer to r7 -> w_enable=0 immediately; r7 unchanged.
REQ-027 Forwarding (WB_FORWARD_EN): w_addr1=9, w_data1=0xA5A5_0000, w_enable=1, r_addr1=9, rf_rdata1=0 -> fwd_data1=0xA5A50000; without the macro -> fwd_data1=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for three requesters feeding one regfile write port.
// Optional WB_FORWARD_EN adds same-cycle write-to-read forwarding on both read ports.
module regfile_wb_arbiter #(
    parameter int unsigned REGADDRSIZE = 5,
    parameter int unsigned REGSIZE     = 32,
    parameter int unsigned NREQ        = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*REGADDRSIZE-1:0] req_addr,
    input  logic [NREQ*REGSIZE-1:0]     req_data,
    output logic [NREQ-1:0]             req_ready,
    input  logic                        wb_hold,
    output logic                        w_enable,
    output logic [REGADDRSIZE-1:0]      w_addr1,
    output logic [REGSIZE-1:0]          w_data1,
    output logic [1:0]                  grant_id,
    input  logic [REGADDRSIZE-1:0]      r_addr1,
    input  logic [REGADDRSIZE-1:0]      r_addr2,
    input  logic [REGSIZE-1:0]          rf_rdata1,
    input  logic [REGSIZE-1:0]          rf_rdata2,
    output logic [REGSIZE-1:0]          fwd_data1,
    output logic [REGSIZE-1:0]          fwd_data2
);

    logic [1:0]             last_grant_q, last_grant_d;
    logic                   w_enable_q, w_enable_d;
    logic [REGADDRSIZE-1:0] w_addr_q, w_addr_d;
    logic [REGSIZE-1:0]     w_data_q, w_data_d;
    logic [1:0]             grant_id_q, grant_id_d;

    logic [1:0]             cand0, cand1, cand2;
    logic [1:0]             gnt_idx;
    logic                   gnt_found;
    logic                   transfer;
    logic [REGADDRSIZE-1:0] sel_addr;
    logic [REGSIZE-1:0]     sel_data;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Search order starts one past the last granted requester.
    always_comb begin
        cand0     = next_idx(last_grant_q);
        cand1     = next_idx(cand0);
        cand2     = next_idx(cand1);
        gnt_idx   = cand0;
        gnt_found = 1'b0;
        if (req_valid[cand0]) begin
            gnt_idx   = cand0;
            gnt_found = 1'b1;
        end else if (req_valid[cand1]) begin
            gnt_idx   = cand1;
            gnt_found = 1'b1;
        end else if (req_valid[cand2]) begin
            gnt_idx   = cand2;
            gnt_found = 1'b1;
        end
        req_ready = '0;
        if (gnt_found && !wb_hold && !reset) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        transfer     = |req_ready;
        sel_addr     = req_addr[gnt_idx*REGADDRSIZE +: REGADDRSIZE];
        sel_data     = req_data[gnt_idx*REGSIZE +: REGSIZE];
        last_grant_d = transfer ? gnt_idx : last_grant_q;
        // Writes to r0 consume a slot but never reach the regfile.
        w_enable_d   = transfer && (sel_addr != '0);
        w_addr_d     = w_enable_d ? sel_addr : w_addr_q;
        w_data_d     = w_enable_d ? sel_data : w_data_q;
        grant_id_d   = w_enable_d ? gnt_idx : 2'b11;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 2'd2;
            w_enable_q   <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            grant_id_q   <= 2'b11;
        end else begin
            last_grant_q <= last_grant_d;
            w_enable_q   <= w_enable_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            grant_id_q   <= grant_id_d;
        end
    end

    assign w_enable = w_enable_q;
    assign w_addr1  = w_addr_q;
    assign w_data1  = w_data_q;
    assign grant_id = grant_id_q;

`ifdef WB_FORWARD_EN
    // Regfile commits on the negedge, so bypass the pending write for the first half-cycle.
    assign fwd_data1 = (w_enable_q && (w_addr_q == r_addr1) && (r_addr1 != '0)) ? w_data_q
                                                                              : rf_rdata1;
    assign fwd_data2 = (w_enable_q && (w_addr_q == r_addr2) && (r_addr2 != '0)) ? w_data_q
                                                                              : rf_rdata2;
`else
    logic unused_raddr;
    assign unused_raddr = ^{r_addr1, r_addr2};
    assign fwd_data1    = rf_rdata1;
    assign fwd_data2    = rf_rdata2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: scoreboard of expected write slots plus a negedge
// regfile model; covers round-robin, r0 writes, hold, serialization, reset and forwarding.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        wb_hold;
    logic        w_enable;
    logic [4:0]  w_addr1;
    logic [31:0] w_data1;
    logic [1:0]  grant_id;
    logic [4:0]  r_addr1, r_addr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [31:0] fwd_data1, fwd_data2;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_hold   (wb_hold),
        .w_enable  (w_enable),
        .w_addr1   (w_addr1),
        .w_data1   (w_data1),
        .grant_id  (grant_id),
        .r_addr1   (r_addr1),
        .r_addr2   (r_addr2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [4:0]  a;
        logic [31:0] d;
        logic [1:0]  g;
    } exp_t;

    exp_t        sb[$];
    logic [4:0]  ta[3];
    logic [31:0] td[3];
    logic [4:0]  last_a;
    logic [31:0] last_d;
    logic [31:0] rf[32];
    int          n_vec;
    int          n_fail;

    // Regfile model commits on the negedge after the write slot is presented.
    always @(negedge clk) begin
        if (w_enable) rf[w_addr1] <= w_data1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        ta[i] = a;
        td[i] = d;
        req_addr[i*5 +: 5]   = a;
        req_data[i*32 +: 32] = d;
    endtask

    // Drive one cycle, check ready mid-cycle, push the expected slot, then compare it.
    task automatic step(input logic [2:0] v, input logic h, input logic [2:0] exp_rdy);
        exp_t e;
        int   idx;
        req_valid = v;
        wb_hold   = h;
        #2;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        idx = exp_rdy[0] ? 0 : exp_rdy[1] ? 1 : 2;
        if (exp_rdy != 3'b000 && ta[idx] != 5'd0) begin
            last_a = ta[idx];
            last_d = td[idx];
            sb.push_back('{en: 1'b1, a: ta[idx], d: td[idx], g: 2'(idx)});
        end else begin
            sb.push_back('{en: 1'b0, a: last_a, d: last_d, g: 2'b11});
        end
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $error("FAIL scoreboard: observed empty expected entry");
        end else begin
            e = sb.pop_front();
            chk("w_enable", 32'(w_enable), 32'(e.en));
            chk("w_addr1", 32'(w_addr1), 32'(e.a));
            chk("w_data1", w_data1, e.d);
            chk("grant_id", 32'(grant_id), 32'(e.g));
        end
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        last_a    = '0;
        last_d    = '0;
        reset     = 1'b1;
        req_valid = 3'b111;
        wb_hold   = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        r_addr1   = '0;
        r_addr2   = '0;
        rf_rdata1 = '0;
        rf_rdata2 = '0;
        set_req(0, 5'd3, 32'h0000_00A0);
        set_req(1, 5'd5, 32'hDEAD_BEEF);
        set_req(2, 5'd10, 32'h0000_00C2);
        #3;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_w_enable", 32'(w_enable), 32'd0);
        chk("rst_w_addr1", 32'(w_addr1), 32'd0);
        chk("rst_w_data1", w_data1, 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd3);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Round-robin with all requesters valid
        step(3'b111, 1'b0, 3'b001);
        step(3'b111, 1'b0, 3'b010);
        step(3'b111, 1'b0, 3'b100);
        step(3'b111, 1'b0, 3'b001);
        step(3'b111, 1'b0, 3'b010);
        step(3'b111, 1'b0, 3'b100);

        // Single request, then an idle cycle holding addr/data
        step(3'b010, 1'b0, 3'b010);
        step(3'b000, 1'b0, 3'b000);

        // Write to r0 consumes a slot without enabling the write
        set_req(0, 5'd0, 32'h0000_1234);
        step(3'b001, 1'b0, 3'b001);
        step(3'b000, 1'b0, 3'b000);
        chk("rf_r0", rf[0], 32'd0);

        // Pointer to 2, then hold with 0 and 2 pending
        set_req(0, 5'd3, 32'h0000_00A0);
        step(3'b100, 1'b0, 3'b100);
        step(3'b101, 1'b1, 3'b000);
        step(3'b101, 1'b1, 3'b000);
        step(3'b101, 1'b1, 3'b000);
        step(3'b101, 1'b0, 3'b001);
        step(3'b101, 1'b0, 3'b100);

        // Same destination: later grant wins
        set_req(1, 5'd7, 32'h0000_1111);
        set_req(2, 5'd7, 32'h0000_2222);
        step(3'b110, 1'b0, 3'b010);
        step(3'b110, 1'b0, 3'b100);
        step(3'b000, 1'b0, 3'b000);
        chk("rf_r7_serial", rf[7], 32'h0000_2222);

        // Reset lands while the r7 write slot is live
        set_req(0, 5'd7, 32'h0000_7777);
        step(3'b001, 1'b0, 3'b001);
        reset = 1'b1;
        #1;
        chk("midrst_w_enable", 32'(w_enable), 32'd0);
        chk("midrst_grant_id", 32'(grant_id), 32'd3);
        chk("midrst_w_addr1", 32'(w_addr1), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("rf_r7_after_rst", rf[7], 32'h0000_2222);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        last_a = '0;
        last_d = '0;

        // Requester 0 first after reset
        set_req(0, 5'd3, 32'h0000_00A0);
        step(3'b111, 1'b0, 3'b001);

        // Forwarding window before the negedge commit
        set_req(2, 5'd9, 32'hA5A5_0000);
        step(3'b100, 1'b0, 3'b100);
        r_addr1   = 5'd9;
        rf_rdata1 = 32'd0;
        r_addr2   = 5'd8;
        rf_rdata2 = 32'h0000_0055;
        #1;
`ifdef WB_FORWARD_EN
        chk("fwd_data1", fwd_data1, 32'hA5A5_0000);
`else
        chk("fwd_data1", fwd_data1, 32'd0);
`endif
        chk("fwd_data2", fwd_data2, 32'h0000_0055);
        r_addr1 = 5'd0;
        r_addr2 = 5'd0;
        step(3'b000, 1'b0, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
